// File: rtl/pwm_driver_if.sv
// Duty-word handshake between the PID controller and the PWM driver.
interface pwm_driver_if;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;

  modport master (output duty_in, duty_valid, input  duty_ready);
  modport slave  (input  duty_in, duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_driver.sv
// Fixed-period PWM generator: duty words are buffered in a one-deep shadow and
// applied at period boundaries through a per-period slew limiter.
module pwm_driver #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned SLEW_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  pwm_driver_if.slave        duty,
  input  logic               enable,
  output logic               pwm_out,
  output logic               period_start,
  output logic [7:0]         duty_active
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_LAST = 8'd254;
  localparam logic [7:0]  STEP     = 8'((SLEW_MAX > 255) ? 255 : SLEW_MAX);

  logic [15:0] pre_q, pre_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  active_q, active_d;
  logic        pending_q, pending_d;

  logic              tick, boundary, xfer;
  logic [7:0]        tgt_new, slewed;
  logic signed [8:0] diff;
  logic [8:0]        mag;

  assign tick     = enable && (pre_q == PRE_LAST);
  assign boundary = tick && (cnt_q == CNT_LAST);
  assign xfer     = duty.duty_valid && duty.duty_ready;

  assign duty.duty_ready = !pending_q && !rst;
  assign duty_active     = active_q;
  assign period_start    = enable && !rst && (pre_q == 16'd0) && (cnt_q == 8'd0);
  assign pwm_out         = enable && !rst && (cnt_q < active_q);

  // Slew toward the target that will be in force after this boundary.
  always_comb begin
    tgt_new = pending_q ? shadow_q : target_q;
    diff    = $signed({1'b0, tgt_new}) - $signed({1'b0, active_q});
    mag     = diff[8] ? 9'(-diff) : 9'(diff);
    slewed  = tgt_new;
    if (SLEW_MAX != 0 && {23'd0, mag} > SLEW_MAX) begin
      slewed = diff[8] ? (active_q - STEP) : (active_q + STEP);
    end
  end

  always_comb begin
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    target_d  = target_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (!enable) begin
      pre_d = 16'd0;
      cnt_d = 8'd0;
      // Idle preset path: a buffered word takes effect at once, unslewed.
      if (pending_q) begin
        target_d  = shadow_q;
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
      if (tick) cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
      if (boundary) begin
        target_d  = tgt_new;
        active_d  = slewed;
        pending_d = 1'b0;
      end
    end

    // Ready implies nothing pending, so a transfer never races a consume.
    if (xfer) begin
      shadow_d  = duty.duty_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= 16'd0;
      cnt_q     <= 8'd0;
      shadow_q  <= 8'd0;
      target_q  <= 8'd0;
      active_q  <= 8'd0;
      pending_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      target_q  <= target_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: doc/pwm_driver.md
# pwm_driver

Downstream stage of the PID controller: takes the 8-bit clamped control word and turns it into a fixed-period PWM waveform for the actuator. Incoming duty values enter through a valid/ready handshake into a shadow register. They are applied only at period boundaries, so no PWM period is ever truncated or glitched. A per-period slew limiter bounds how fast the applied duty can move.

## Interface

Parameters:
- PRESCALE, default 4: clocks per PWM tick; legal range 1..65535.
- SLEW_MAX, default 16: maximum change of the applied duty per period; 0 disables limiting (snap to target).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- duty_in  input  8  requested duty, 0..255; 0 = always low, 255 = always high.
- duty_valid  input  1  duty_in is valid this cycle.
- duty_ready  output  1  shadow register empty; a transfer occurs on an edge with duty_valid && duty_ready.
- enable  input  1  run PWM; when low, output is forced low and counters are held.
- pwm_out  output  1  PWM waveform; combinational decode of registered state: enable && (cnt < duty_active).
- period_start  output  1  high for the first clock of every PWM period.
- duty_active  output  8  duty currently being applied.

## Operation

- Prescaler `pre`, 0..PRESCALE-1, increments every clock while enable is high. `tick` = enable && (pre == PRESCALE-1).
- Period counter `cnt`, 0..254, advances on tick and wraps from 254 to 0. The period is 255 ticks, i.e. PRESCALE*255 clocks.
- `boundary` = tick && cnt == 254, the edge that starts a new period.
- Handshake:
  - duty_ready = !pending && !rst.
  - On a transfer, shadow <= duty_in and pending <= 1.
- Boundary update, evaluated at the boundary edge using pre-edge values:
  - If pending: target <= shadow, pending <= 0.
  - duty_active moves toward the new target, or the current target if nothing is pending.
  - d = target_new - duty_active, computed as a 9-bit signed value.
  - If SLEW_MAX == 0 or |d| <= SLEW_MAX: duty_active <= target_new.
  - Otherwise duty_active <= duty_active ± SLEW_MAX, with the sign of d.
  - The result always stays within 0..255; no wrap.
- A transfer landing on the same edge as a boundary is not consumed by that boundary. It sets pending and is applied at the next boundary.
- Disabled, enable low:
  - pre and cnt are forced to 0 and pwm_out is 0.
  - If pending, target and duty_active snap to shadow on the next edge, with no slew limiting, and pending clears. This allows presetting the duty before start.
- Re-enable: the first clock with enable high has pre == 0 and cnt == 0, which is a period start.
- period_start = enable && pre == 0 && cnt == 0.

## Timing

- Reset, when rst is sampled high:
  - pre, cnt, shadow, target and duty_active all become 0; pending becomes 0.
  - pwm_out = 0, period_start = 0 and duty_ready = 0 while rst is high.
  - duty_ready = 1 on the first cycle after rst deasserts.
- Reset mid-period aborts the current period immediately and discards any pending value. With enable high, the first period starts on the first cycle after reset.
- pwm_out high time per period = PRESCALE*duty_active clocks, starting at the period_start cycle; duty 255 gives a continuous high level.
- Latency from accepted duty to application:
  - The next boundary edge, or the one after if accepted on a boundary edge.
  - The new duty_active is visible in the period_start cycle of the new period.
- duty_ready drops the cycle after a transfer and rises the cycle after the consuming boundary, or after the disabled snap.
- At most one value is buffered. A producer faster than one value per period is back-pressured; values are never dropped.

## Test plan

- Reset: hold rst 3 cycles with duty_valid = 1 and enable = 1 → pwm_out = 0, duty_ready = 0, duty_active = 0 during reset. After release: duty_ready = 1 and period_start = 1 on the first cycle, then every 1020 clocks.
- Slew ramp, defaults: send 64 from duty_active = 0 → successive periods show duty_active 16, 32, 48, 64, 64 and pwm_out high for 64, 128, 192, 256, 256 clocks. Then send 0 → 48, 32, 16, 0.
- Extremes, SLEW_MAX = 0 build: duty 0 → pwm_out never high over 1020 clocks. Duty 255 → pwm_out continuously high across period boundaries.
- Back-pressure: send 100 and 200 back-to-back mid-period (SLEW_MAX = 0):
  - 100 is accepted; 200 waits with duty_ready low.
  - Period N+1 applies 100; 200 is accepted after boundary N+1 and applied in period N+2.
  - A transfer landing exactly on a boundary edge is applied one boundary later.
- Enable: drop enable mid-period → pwm_out = 0 the same cycle and cnt = 0. Send 180 while disabled → duty_active = 180 next edge, no slew. Raise enable → period_start the same cycle and 720 clocks high.
- Reset mid-operation: during a ramp toward 200 with a pending value, assert rst for 1 cycle → all state returns to 0, the pending value is discarded, and the next period has duty_active = 0.
